// File: rtl/hires_blit_ctrl.sv
// Port-A sequencer for the hi-res graphics RAM: arbitrates Z80 byte accesses
// against a FILL / INVERT rectangle engine, Z80 taking any free slot first.
module hires_blit_ctrl (
    input  logic        clk,
    input  logic        srst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [6:0]  cmd_x0,
    input  logic [7:0]  cmd_y0,
    input  logic [6:0]  cmd_w,
    input  logic [7:0]  cmd_h,
    input  logic [7:0]  cmd_data,
    output logic        busy,
    output logic        done,
    input  logic        z80_req,
    input  logic        z80_we,
    input  logic [14:0] z80_addr,
    input  logic [7:0]  z80_din,
    output logic        z80_ack,
    output logic [7:0]  z80_dout,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_oce,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL_WR = 3'd1,
        S_INV_RD  = 3'd2,
        S_INV_W1  = 3'd3,
        S_INV_W2  = 3'd4,
        S_INV_WR  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t      state_r, state_s;
    logic [6:0]  x0_r, x_r, w_r, col_r;
    logic [7:0]  y_r, h_r, row_r, data_r, cap_r, dout_r;
    logic        z_wr_p1_r, rd_p1_r, rd_p2_r, own_p1_r, own_p2_r;

    logic        z80_busy_s, z80_grant_s, eng_want_s, eng_wr_s, eng_go_s;
    logic        last_col_s, last_row_s, z80_rd_ret_s;

    // Slot arbitration: a Z80 request with nothing of its own in flight owns the slot.
    always_comb begin
        z80_busy_s   = z_wr_p1_r | (rd_p1_r & own_p1_r) | (rd_p2_r & own_p2_r);
        z80_grant_s  = z80_req & ~z80_busy_s & ~srst;
        eng_wr_s     = (state_r == S_FILL_WR) || (state_r == S_INV_WR);
        eng_want_s   = eng_wr_s || (state_r == S_INV_RD);
        eng_go_s     = eng_want_s & ~z80_grant_s & ~srst;
        last_col_s   = (col_r == (w_r - 7'd1));
        last_row_s   = (row_r == (h_r - 8'd1));
        z80_rd_ret_s = rd_p2_r & own_p2_r;
    end

    // RAM port drive for whichever requester owns this slot.
    always_comb begin
        ram_ce   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = {x_r, y_r};
        ram_din  = data_r;
        if (z80_grant_s) begin
            ram_ce   = 1'b1;
            ram_we   = z80_we;
            ram_addr = z80_addr;
            ram_din  = z80_din;
        end else if (eng_go_s) begin
            ram_ce   = 1'b1;
            ram_we   = eng_wr_s;
            ram_addr = {x_r, y_r};
            ram_din  = (state_r == S_INV_WR) ? (cap_r ^ 8'hFF) : data_r;
        end else begin
            ram_ce   = 1'b0;
        end
    end

    // Engine next-state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_w == 7'd0) || (cmd_h == 8'd0)) begin
                        state_s = S_DONE;
                    end else if (cmd_op) begin
                        state_s = S_INV_RD;
                    end else begin
                        state_s = S_FILL_WR;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FILL_WR: begin
                if (eng_go_s && last_col_s && last_row_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_FILL_WR;
                end
            end
            S_INV_RD: begin
                if (eng_go_s) begin
                    state_s = S_INV_W1;
                end else begin
                    state_s = S_INV_RD;
                end
            end
            S_INV_W1: state_s = S_INV_W2;
            S_INV_W2: state_s = S_INV_WR;
            S_INV_WR: begin
                if (eng_go_s) begin
                    state_s = (last_col_s && last_row_s) ? S_DONE : S_INV_RD;
                end else begin
                    state_s = S_INV_WR;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Engine registers, rectangle walk and read-return pipeline with owner tag.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r   <= S_IDLE;
            x0_r      <= 7'd0;
            x_r       <= 7'd0;
            w_r       <= 7'd0;
            col_r     <= 7'd0;
            y_r       <= 8'd0;
            h_r       <= 8'd0;
            row_r     <= 8'd0;
            data_r    <= 8'd0;
            cap_r     <= 8'd0;
            dout_r    <= 8'd0;
            z_wr_p1_r <= 1'b0;
            rd_p1_r   <= 1'b0;
            rd_p2_r   <= 1'b0;
            own_p1_r  <= 1'b0;
            own_p2_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == S_IDLE) && cmd_valid) begin
                x0_r   <= cmd_x0;
                x_r    <= cmd_x0;
                y_r    <= cmd_y0;
                w_r    <= cmd_w;
                h_r    <= cmd_h;
                data_r <= cmd_data;
                col_r  <= 7'd0;
                row_r  <= 8'd0;
            end else if (eng_go_s && eng_wr_s) begin
                if (last_col_s) begin
                    col_r <= 7'd0;
                    x_r   <= x0_r;
                    y_r   <= y_r + 8'd1;
                    row_r <= row_r + 8'd1;
                end else begin
                    col_r <= col_r + 7'd1;
                    x_r   <= x_r + 7'd1;
                end
            end else begin
                col_r <= col_r;
            end
            if ((state_r == S_INV_W2) && rd_p2_r && !own_p2_r) begin
                cap_r <= ram_dout;
            end
            if (z80_rd_ret_s) begin
                dout_r <= ram_dout;
            end
            z_wr_p1_r <= z80_grant_s & z80_we;
            rd_p1_r   <= ram_ce & ~ram_we;
            own_p1_r  <= z80_grant_s;
            rd_p2_r   <= rd_p1_r;
            own_p2_r  <= own_p1_r;
        end
    end

    assign cmd_ready = (state_r == S_IDLE);
    assign busy      = (state_r != S_IDLE);
    assign done      = (state_r == S_DONE);
    assign ram_oce   = rd_p1_r;
    assign z80_ack   = z_wr_p1_r | z80_rd_ret_s;
    // Read data is forwarded straight from the RAM on the ack cycle, then held.
    assign z80_dout  = z80_rd_ret_s ? ram_dout : dout_r;

endmodule

// File: tb/tb_hires_blit_ctrl.sv
// Scoreboard bench for hires_blit_ctrl: expected RAM issues, done pulses and
// Z80 acks are queued at stimulus time and matched as the DUT produces them.
module tb_hires_blit_ctrl;

    logic        clk = 1'b0;
    logic        srst;
    logic        cmd_valid, cmd_ready, cmd_op;
    logic [6:0]  cmd_x0, cmd_w;
    logic [7:0]  cmd_y0, cmd_h, cmd_data;
    logic        busy, done;
    logic        z80_req, z80_we, z80_ack;
    logic [14:0] z80_addr;
    logic [7:0]  z80_din, z80_dout;
    logic        ram_ce, ram_we, ram_oce;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din, ram_dout;

    hires_blit_ctrl dut (
        .clk(clk), .srst(srst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_data(cmd_data), .busy(busy), .done(done),
        .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr),
        .z80_din(z80_din), .z80_ack(z80_ack), .z80_dout(z80_dout),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_oce(ram_oce), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: 2-cycle read (issue, output-register enable), plus a preload port.
    logic [7:0]  mem [0:32767];
    logic [7:0]  lat_r, rdo_r;
    logic        pre_en = 1'b0;
    logic [14:0] pre_addr = 15'd0;
    logic [7:0]  pre_data = 8'd0;
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (ram_ce && ram_we) mem[ram_addr] <= ram_din;
        if (ram_ce && !ram_we) lat_r <= mem[ram_addr];
        if (ram_oce) rdo_r <= lat_r;
    end
    assign ram_dout = rdo_r;

    typedef struct {
        int          cyc;
        logic [14:0] addr;
        logic [7:0]  data;
    } ev_t;
    typedef struct {
        int         cyc;
        bit         rd;
        logic [7:0] data;
    } ack_t;

    ev_t  wq[$];
    ev_t  rq[$];
    int   dq[$];
    ack_t aq[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: sample mid-cycle and match every DUT event against the scoreboard.
    bit prev_rd = 1'b0;
    bit prev_srst = 1'b1;
    always @(negedge clk) begin
        ev_t  e;
        ack_t a;
        int   d;
        if (!srst) begin
            if (ram_ce && ram_we) begin
                if (wq.size() == 0) check_val("unexp_wr", 64'd1, 64'd0);
                else begin
                    e = wq.pop_front();
                    check_val("ram_wr", {cyc, ram_addr, ram_din}, {e.cyc, e.addr, e.data});
                end
            end
            if (ram_ce && !ram_we) begin
                if (rq.size() == 0) check_val("unexp_rd", 64'd1, 64'd0);
                else begin
                    e = rq.pop_front();
                    check_val("ram_rd", {cyc, ram_addr}, {e.cyc, e.addr});
                end
            end
            if (done) begin
                if (dq.size() == 0) check_val("unexp_done", 64'd1, 64'd0);
                else begin
                    d = dq.pop_front();
                    check_val("done_cyc", cyc, d);
                end
            end
            if (z80_ack) begin
                if (aq.size() == 0) check_val("unexp_ack", 64'd1, 64'd0);
                else begin
                    a = aq.pop_front();
                    check_val("ack_cyc", cyc, a.cyc);
                    if (a.rd) check_val("z80_dout", z80_dout, a.data);
                end
            end
            if ((ram_oce || prev_rd) && !prev_srst) check_val("ram_oce", ram_oce, prev_rd);
        end
        prev_rd   = ram_ce && !ram_we && !srst;
        prev_srst = srst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [14:0] addr, input logic [7:0] data);
        pre_en = 1'b1; pre_addr = addr; pre_data = data;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic send_cmd(input logic op, input logic [6:0] x0, input logic [7:0] y0,
                            input logic [6:0] w, input logic [7:0] h, input logic [7:0] d,
                            output int a);
        for (int i = 0; i < 200 && !cmd_ready; i++) tick();
        check_val("cmd_ready_idle", cmd_ready, 1'b1);
        a = cyc;
        cmd_valid = 1'b1; cmd_op = op; cmd_x0 = x0; cmd_y0 = y0;
        cmd_w = w; cmd_h = h; cmd_data = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Expected FILL writes; an optional Z80 write at cycle zc takes one slot,
    // and limit truncates the expected stream (no done) for reset tests.
    task automatic exp_fill(input int a, input logic [6:0] x0, input logic [7:0] y0,
                            input logic [6:0] w, input logic [7:0] h, input logic [7:0] d,
                            input int zc, input logic [14:0] za, input logic [7:0] zd,
                            input int limit);
        int t = a + 1;
        int n = 0;
        logic [6:0] xx;
        logic [7:0] yy;
        for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
                if (limit >= 0 && n == limit) return;
                if (t == zc) begin
                    wq.push_back('{zc, za, zd});
                    t++;
                end
                xx = x0 + 7'(c);
                yy = y0 + 8'(r);
                wq.push_back('{t, {xx, yy}, d});
                t++;
                n++;
            end
        end
        if (limit < 0) dq.push_back(t);
    endtask

    task automatic exp_inv(input int a, input logic [6:0] x0, input logic [7:0] y0,
                           input logic [6:0] w, input logic [7:0] h);
        int t = a + 1;
        logic [6:0] xx;
        logic [7:0] yy;
        for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
                xx = x0 + 7'(c);
                yy = y0 + 8'(r);
                rq.push_back('{t, {xx, yy}, 8'h00});
                wq.push_back('{t + 3, {xx, yy}, ~mem[{xx, yy}]});
                t += 4;
            end
        end
        dq.push_back(t);
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (wq.size() + rq.size() + dq.size() + aq.size() == 0) break;
            tick();
        end
        check_val("drain", wq.size() + rq.size() + dq.size() + aq.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        int a, t;
        srst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_x0 = 7'd0; cmd_y0 = 8'd0;
        cmd_w = 7'd0; cmd_h = 8'd0; cmd_data = 8'd0;
        z80_req = 1'b0; z80_we = 1'b0; z80_addr = 15'd0; z80_din = 8'd0;
        repeat (3) tick();
        check_val("rst_outs", {cmd_ready, busy, done, z80_ack, ram_ce, ram_we, ram_oce},
                  7'b1000000);
        check_val("rst_dout", z80_dout, 8'h00);
        srst = 1'b0;
        preload({7'd0, 8'd0}, 8'h3C);
        preload({7'd2, 8'd3}, 8'h5A);
        for (int i = 0; i < 4; i++) preload({7'd40 + 7'(i), 8'd100}, 8'($urandom_range(0, 255)));
        tick();

        // FILL 2x2
        send_cmd(1'b0, 7'd5, 8'd10, 7'd2, 8'd2, 8'hAA, a);
        exp_fill(a, 7'd5, 8'd10, 7'd2, 8'd2, 8'hAA, -1, 15'd0, 8'd0, -1);
        check_val("busy_a1", {busy, cmd_ready}, 2'b10);
        drain(100);

        // INVERT single byte 3C -> C3
        send_cmd(1'b1, 7'd0, 8'd0, 7'd1, 8'd1, 8'h00, a);
        exp_inv(a, 7'd0, 8'd0, 7'd1, 8'd1);
        drain(100);
        check_val("inv_mem", mem[15'd0], 8'hC3);

        // INVERT 2x2 over random data
        send_cmd(1'b1, 7'd40, 8'd100, 7'd2, 8'd2, 8'h00, a);
        exp_inv(a, 7'd40, 8'd100, 7'd2, 8'd2);
        drain(100);

        // Z80 write steals one slot in a FILL w=4 h=1
        send_cmd(1'b0, 7'd20, 8'd30, 7'd4, 8'd1, 8'h77, a);
        exp_fill(a, 7'd20, 8'd30, 7'd4, 8'd1, 8'h77, a + 2, {7'd50, 8'd60}, 8'h99, -1);
        aq.push_back('{a + 3, 1'b0, 8'h00});
        tick();
        z80_req = 1'b1; z80_we = 1'b1; z80_addr = {7'd50, 8'd60}; z80_din = 8'h99;
        tick();
        tick();
        z80_req = 1'b0;
        drain(100);

        // Z80 read while idle
        t = cyc;
        z80_req = 1'b1; z80_we = 1'b0; z80_addr = {7'd2, 8'd3};
        rq.push_back('{t, {7'd2, 8'd3}, 8'h00});
        aq.push_back('{t + 2, 1'b1, 8'h5A});
        tick(); tick(); tick();
        z80_req = 1'b0;
        drain(50);
        check_val("dout_hold", z80_dout, 8'h5A);

        // x wrap 127 -> 0
        send_cmd(1'b0, 7'd127, 8'd20, 7'd2, 8'd1, 8'h5C, a);
        exp_fill(a, 7'd127, 8'd20, 7'd2, 8'd1, 8'h5C, -1, 15'd0, 8'd0, -1);
        drain(100);

        // w == 0: done at A+1, no RAM issue
        send_cmd(1'b0, 7'd9, 8'd9, 7'd0, 8'd3, 8'h11, a);
        exp_fill(a, 7'd9, 8'd9, 7'd0, 8'd3, 8'h11, -1, 15'd0, 8'd0, -1);
        drain(50);

        // srst after 3 of 6 writes: no further writes, no done
        send_cmd(1'b0, 7'd10, 8'd50, 7'd3, 8'd2, 8'h11, a);
        exp_fill(a, 7'd10, 8'd50, 7'd3, 8'd2, 8'h11, -1, 15'd0, 8'd0, 3);
        tick(); tick(); tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check_val("srst_idle", {cmd_ready, busy, done, z80_ack}, 4'b1000);
        repeat (10) tick();
        drain(20);

        // New command after reset
        send_cmd(1'b0, 7'd60, 8'd200, 7'd3, 8'd1, 8'hE7, a);
        exp_fill(a, 7'd60, 8'd200, 7'd3, 8'd1, 8'hE7, -1, 15'd0, 8'd0, -1);
        drain(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
